// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data RAM arbiter.
// State encodings, RAM write-enable codes and load/store size codes live here.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    // One-hot RAM write enable; all-zero means read.
    typedef enum logic [2:0] {
        WE_NONE = 3'b000,
        WE_WORD = 3'b001,
        WE_HALF = 3'b010,
        WE_BYTE = 3'b100
    } we_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } port_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Size code 3 is not a legal access size; it is folded into a word store.
    function automatic we_t size_to_we(input logic [1:0] size);
        we_t we;
        case (size)
            SZ_B:    we = WE_BYTE;
            SZ_H:    we = WE_HALF;
            SZ_W:    we = WE_WORD;
            default: we = WE_WORD;
        endcase
        return we;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and the RAM.
// The slave view is the arbiter; the master view is everything around it.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic [ADDR_W-1:0] ram_addr;
    logic [2:0]        ram_we;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  i_req, i_addr,
        output i_ack, i_rdata,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_ack, d_rdata,
        output ram_addr, ram_we, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output i_req, i_addr,
        input  i_ack, i_rdata,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  ram_addr, ram_we, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin grant; purely combinational.
// grant is one-hot: bit 0 = instruction fetch, bit 1 = data port.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic       req_i,
    input  logic       req_d,
    input  port_t      last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (req_i && req_d) begin
            // Contention goes to whichever port was not served last.
            grant = (last_grant == GNT_I) ? 2'b10 : 2'b01;
        end else if (req_i) begin
            grant = 2'b01;
        end else if (req_d) begin
            grant = 2'b10;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous RAM between the fetch and load/store ports.
//   state     | meaning
//   ST_IDLE   | sample requests, register winner's address/we/wdata
//   ST_ACCESS | RAM sees address and write enable; we cleared on exit
//   ST_RESP   | winner's ack pulses, rdata taken straight from the RAM
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus
);

    state_t            state;
    state_t            state_next;
    port_t             last_grant;
    logic [1:0]        win;
    logic              start;
    logic              i_ack;
    logic              d_ack;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    we_t               we_q;

    rr_arb2 u_rr_arb2 (
        .req_i      (bus.i_req),
        .req_d      (bus.d_req),
        .last_grant (last_grant),
        .grant      (win)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        i_ack      = 1'b0;
        d_ack      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win != 2'b00) begin
                    start      = 1'b1;
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_next = ST_RESP;
            end
            ST_RESP: begin
                i_ack      = (last_grant == GNT_I);
                d_ack      = (last_grant == GNT_D);
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // last_grant is updated on entry to ACCESS, so it also names the port
    // being served for the rest of this access.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= WE_NONE;
            last_grant <= GNT_I;
        end else if (start) begin
            if (win[1]) begin
                addr_q     <= bus.d_addr;
                wdata_q    <= bus.d_wdata;
                we_q       <= bus.d_we ? size_to_we(bus.d_size) : WE_NONE;
                last_grant <= GNT_D;
            end else begin
                addr_q     <= bus.i_addr;
                we_q       <= WE_NONE;
                last_grant <= GNT_I;
            end
        end else if (state == ST_ACCESS) begin
            we_q <= WE_NONE;
        end
    end

    assign bus.ram_addr  = addr_q;
    assign bus.ram_we    = we_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.i_ack     = i_ack;
    assign bus.d_ack     = d_ack;
    assign bus.i_rdata   = bus.ram_rdata;
    assign bus.d_rdata   = bus.ram_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter with a byte-lane RAM model and a
// transaction-level reference model of the arbitration and memory contents.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    bit [31:0]   ram     [256];
    bit [31:0]   ref_mem [256];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = 8'd0;
    logic [31:0] pre_data = 32'd0;

    // RAM places the bytes of a narrow store into the lane chosen by the address.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] off,
                                          input int nbytes, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        case (nbytes)
            1:       r[8*off +: 8]     = wd[7:0];
            2:       r[16*off[1] +: 16] = wd[15:0];
            default: r = wd;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (pre_en) begin
            ram[pre_idx] <= pre_data;
        end else begin
            case (bus.ram_we)
                3'b100:  ram[bus.ram_addr[9:2]] <= merge(ram[bus.ram_addr[9:2]], bus.ram_addr[1:0], 1, bus.ram_wdata);
                3'b010:  ram[bus.ram_addr[9:2]] <= merge(ram[bus.ram_addr[9:2]], bus.ram_addr[1:0], 2, bus.ram_wdata);
                3'b001:  ram[bus.ram_addr[9:2]] <= bus.ram_wdata;
                default: ;
            endcase
        end
        bus.ram_rdata <= ram[bus.ram_addr[9:2]];
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pre_en   = 1'b1;
        pre_idx  = idx;
        pre_data = data;
        step();
        pre_en       = 1'b0;
        ref_mem[idx] = data;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_size = 2'd0; bus.d_addr = '0; bus.d_wdata = '0;
        do_reset();
        checks += 5;
        if (bus.ram_we !== 3'b000) begin failures++; $display("FAIL reset_ram_we: got %b expected 000", bus.ram_we); end
        if (bus.ram_addr !== 32'd0) begin failures++; $display("FAIL reset_ram_addr: got %h expected 0", bus.ram_addr); end
        if (bus.ram_wdata !== 32'd0) begin failures++; $display("FAIL reset_ram_wdata: got %h expected 0", bus.ram_wdata); end
        if (bus.i_ack !== 1'b0) begin failures++; $display("FAIL reset_i_ack: got %b expected 0", bus.i_ack); end
        if (bus.d_ack !== 1'b0) begin failures++; $display("FAIL reset_d_ack: got %b expected 0", bus.d_ack); end
    endtask

    task automatic test_lone_fetch();
        int d_seen;
        d_seen = 0;
        preload(8'd4, 32'hDEADBEEF);
        bus.i_req  = 1'b1;
        bus.i_addr = 32'h10;
        step();
        if (bus.d_ack) d_seen++;
        checks += 3;
        if (bus.ram_addr !== 32'h10) begin failures++; $display("FAIL fetch_addr: got %h expected 00000010", bus.ram_addr); end
        if (bus.ram_we !== 3'b000) begin failures++; $display("FAIL fetch_we: got %b expected 000", bus.ram_we); end
        if (bus.i_ack !== 1'b0) begin failures++; $display("FAIL fetch_early_ack: got %b expected 0", bus.i_ack); end
        step();
        if (bus.d_ack) d_seen++;
        checks += 2;
        if (bus.i_ack !== 1'b1) begin failures++; $display("FAIL fetch_ack: got %b expected 1", bus.i_ack); end
        if (bus.i_rdata !== ref_mem[4]) begin failures++; $display("FAIL fetch_rdata: got %h expected %h", bus.i_rdata, ref_mem[4]); end
        bus.i_req = 1'b0;
        step();
        if (bus.d_ack) d_seen++;
        checks += 2;
        if (bus.i_ack !== 1'b0) begin failures++; $display("FAIL fetch_ack_width: got %b expected 0", bus.i_ack); end
        if (d_seen !== 0) begin failures++; $display("FAIL fetch_no_d_ack: got %0d expected 0", d_seen); end
    endtask

    task automatic test_byte_store();
        int we_cnt;
        we_cnt = 0;
        preload(8'd8, 32'h0);
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'd0;
        bus.d_addr = 32'h20; bus.d_wdata = 32'h000000AB;
        ref_mem[8] = merge(ref_mem[8], 2'd0, 1, 32'h000000AB);
        step();
        if (bus.ram_we !== 3'b000) we_cnt++;
        checks++;
        if (bus.ram_we !== 3'b100) begin failures++; $display("FAIL byte_we: got %b expected 100", bus.ram_we); end
        step();
        if (bus.ram_we !== 3'b000) we_cnt++;
        checks++;
        if (bus.d_ack !== 1'b1) begin failures++; $display("FAIL byte_ack: got %b expected 1", bus.d_ack); end
        bus.d_req = 1'b0;
        step();
        if (bus.ram_we !== 3'b000) we_cnt++;
        checks++;
        if (we_cnt !== 1) begin failures++; $display("FAIL byte_we_cycles: got %0d expected 1", we_cnt); end
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h20;
        step();
        step();
        checks += 2;
        if (bus.d_ack !== 1'b1) begin failures++; $display("FAIL byte_load_ack: got %b expected 1", bus.d_ack); end
        if (bus.d_rdata !== ref_mem[8]) begin failures++; $display("FAIL byte_load_data: got %h expected %h", bus.d_rdata, ref_mem[8]); end
        bus.d_req = 1'b0;
        step();
    endtask

    task automatic test_size3_store();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'd3;
        bus.d_addr = 32'h30; bus.d_wdata = 32'h12345678;
        ref_mem[12] = merge(ref_mem[12], 2'd0, 4, 32'h12345678);
        step();
        checks++;
        if (bus.ram_we !== 3'b001) begin failures++; $display("FAIL size3_we: got %b expected 001", bus.ram_we); end
        step();
        bus.d_req = 1'b0;
        step();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h30;
        step();
        step();
        checks += 2;
        if (bus.d_ack !== 1'b1) begin failures++; $display("FAIL size3_load_ack: got %b expected 1", bus.d_ack); end
        if (bus.d_rdata !== ref_mem[12]) begin failures++; $display("FAIL size3_load_data: got %h expected %h", bus.d_rdata, ref_mem[12]); end
        bus.d_req = 1'b0;
        step();
    endtask

    task automatic test_contention();
        bit last_d;
        bit exp_i;
        bit exp_d;
        int overlap;
        overlap = 0;
        do_reset();
        preload(8'd16, 32'hA5A50001);
        preload(8'd17, 32'h0BADF00D);
        last_d = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h40;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'd2; bus.d_addr = 32'h44;
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_i = 1'b0;
            exp_d = 1'b0;
            // Both ports always request, so each access slot goes to the other port.
            if (c >= 2 && (c - 2) % 3 == 0) begin
                last_d = ~last_d;
                exp_d  = last_d;
                exp_i  = ~last_d;
            end
            if (bus.i_ack && bus.d_ack) overlap++;
            checks += 2;
            if (bus.i_ack !== exp_i) begin failures++; $display("FAIL contend_i_ack c=%0d: got %b expected %b", c, bus.i_ack, exp_i); end
            if (bus.d_ack !== exp_d) begin failures++; $display("FAIL contend_d_ack c=%0d: got %b expected %b", c, bus.d_ack, exp_d); end
            if (exp_i) begin
                checks++;
                if (bus.i_rdata !== ref_mem[16]) begin failures++; $display("FAIL contend_i_rdata: got %h expected %h", bus.i_rdata, ref_mem[16]); end
            end
            if (exp_d) begin
                checks++;
                if (bus.d_rdata !== ref_mem[17]) begin failures++; $display("FAIL contend_d_rdata: got %h expected %h", bus.d_rdata, ref_mem[17]); end
            end
        end
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        checks++;
        if (overlap !== 0) begin failures++; $display("FAIL contend_overlap: got %0d expected 0", overlap); end
        step();
        step();
    endtask

    task automatic test_reset_mid_access();
        int acks;
        acks = 0;
        do_reset();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'd2;
        bus.d_addr = 32'h50; bus.d_wdata = 32'h55AA55AA;
        step();
        checks++;
        if (bus.ram_we !== 3'b001) begin failures++; $display("FAIL midrst_store_we: got %b expected 001", bus.ram_we); end
        reset = 1'b1;
        bus.d_req = 1'b0;
        step();
        if (bus.i_ack || bus.d_ack) acks++;
        checks++;
        if (bus.ram_we !== 3'b000) begin failures++; $display("FAIL midrst_we_cleared: got %b expected 000", bus.ram_we); end
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (bus.i_ack || bus.d_ack) acks++;
        end
        checks++;
        if (acks !== 0) begin failures++; $display("FAIL midrst_no_ack: got %0d expected 0", acks); end
        bus.i_req = 1'b1; bus.i_addr = 32'h10;
        step();
        step();
        checks += 2;
        if (bus.i_ack !== 1'b1) begin failures++; $display("FAIL midrst_fetch_ack: got %b expected 1", bus.i_ack); end
        if (bus.i_rdata !== ref_mem[4]) begin failures++; $display("FAIL midrst_fetch_data: got %h expected %h", bus.i_rdata, ref_mem[4]); end
        bus.i_req = 1'b0;
        step();
    endtask

    task automatic test_random();
        bit          last_d;
        bit          wi, wd, dwe, d_first;
        logic [1:0]  dsz, off;
        logic [31:0] ia, da, dwd, exp_i_data, exp_d_data;
        int          nb, ci, cd, we_cnt;
        do_reset();
        last_d = 1'b0;
        for (int it = 0; it < 40; it++) begin
            wi  = 1'($urandom_range(0, 1));
            wd  = 1'($urandom_range(0, 1));
            if (!wi && !wd) wd = 1'b1;
            dwe = 1'($urandom_range(0, 1));
            dsz = 2'($urandom_range(0, 3));
            nb  = (dsz == 2'd0) ? 1 : (dsz == 2'd1) ? 2 : 4;
            off = (nb == 1) ? 2'($urandom_range(0, 3)) : (nb == 2) ? {1'($urandom_range(0, 1)), 1'b0} : 2'b00;
            ia  = 32'($urandom_range(0, 15)) << 2;
            da  = (32'($urandom_range(0, 15)) << 2) | {30'd0, off};
            dwd = $urandom;

            d_first = wd && (!wi || !last_d);
            ci = 0;
            cd = 0;
            if (wi && wd) begin
                cd = d_first ? 2 : 5;
                ci = d_first ? 5 : 2;
                last_d = ~d_first;
            end else if (wd) begin
                cd = 2;
                last_d = 1'b1;
            end else begin
                ci = 2;
                last_d = 1'b0;
            end
            exp_d_data = '0;
            exp_i_data = '0;
            // Apply the two accesses to the reference memory in service order.
            for (int p = 0; p < 2; p++) begin
                if (wd && ((p == 0) == d_first)) begin
                    if (dwe) ref_mem[da[9:2]] = merge(ref_mem[da[9:2]], da[1:0], nb, dwd);
                    else     exp_d_data = ref_mem[da[9:2]];
                end
                if (wi && ((p == 0) != d_first)) exp_i_data = ref_mem[ia[9:2]];
            end

            bus.i_req = wi; bus.i_addr = ia;
            bus.d_req = wd; bus.d_we = dwe; bus.d_size = dsz; bus.d_addr = da; bus.d_wdata = dwd;
            we_cnt = 0;
            for (int c = 1; c <= 7; c++) begin
                step();
                if (bus.ram_we !== 3'b000) we_cnt++;
                checks += 2;
                if (bus.i_ack !== (c == ci)) begin failures++; $display("FAIL rand_i_ack it=%0d c=%0d: got %b expected %b", it, c, bus.i_ack, (c == ci)); end
                if (bus.d_ack !== (c == cd)) begin failures++; $display("FAIL rand_d_ack it=%0d c=%0d: got %b expected %b", it, c, bus.d_ack, (c == cd)); end
                if (c == ci) begin
                    checks++;
                    if (bus.i_rdata !== exp_i_data) begin failures++; $display("FAIL rand_i_rdata it=%0d: got %h expected %h", it, bus.i_rdata, exp_i_data); end
                    bus.i_req = 1'b0;
                end
                if (c == cd) begin
                    if (!dwe) begin
                        checks++;
                        if (bus.d_rdata !== exp_d_data) begin failures++; $display("FAIL rand_d_rdata it=%0d: got %h expected %h", it, bus.d_rdata, exp_d_data); end
                    end
                    bus.d_req = 1'b0;
                end
            end
            bus.i_req = 1'b0;
            bus.d_req = 1'b0;
            checks++;
            if (we_cnt !== ((wd && dwe) ? 1 : 0)) begin failures++; $display("FAIL rand_we_cycles it=%0d: got %0d expected %0d", it, we_cnt, (wd && dwe) ? 1 : 0); end
        end
    endtask

    initial begin
        reset = 1'b1;
        test_reset();
        test_lone_fetch();
        test_byte_store();
        test_size3_store();
        test_contention();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
